// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter, S_COUNT AXI-Stream
// sources onto one registered AXI-Stream output. Grant held until tlast.
// Ports: clk, rst (async, active-high);
//   s_axis_tdata/tkeep/tvalid/tlast in, s_axis_tready out (packed per stream);
//   m_axis_tdata/tkeep/tvalid/tlast out, m_axis_tready in.
// Option: define AXIS_ARB_SRC_ID_EN to add m_axis_tid (granted stream index).
module axis_rr_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  localparam int GW        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
`ifdef AXIS_ARB_SRC_ID_EN
  output logic [GW-1:0]                 m_axis_tid,
`endif
  output logic                          m_axis_tlast
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_n;

  // last_grant doubles as the current grant while BUSY
  logic [GW-1:0] last_grant, last_grant_n;
  logic [GW-1:0] pick;
  logic          found;

  logic                  out_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;

  // Round-robin search starting just after the previous grant
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    for (int k = 1; k <= S_COUNT; k++) begin
      if (!found && s_axis_tvalid[(int'(last_grant) + k) % S_COUNT]) begin
        found = 1'b1;
        pick  = GW'((int'(last_grant) + k) % S_COUNT);
      end
    end
  end

  assign sel_data  = s_axis_tdata[int'(last_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_axis_tkeep[int'(last_grant)*KEEP_WIDTH +: KEEP_WIDTH];
  assign sel_valid = s_axis_tvalid[last_grant];
  assign sel_last  = s_axis_tlast[last_grant];

  // Output register can take a beat when empty or draining this cycle
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign accept    = (state == BUSY) && sel_valid && out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state == BUSY) begin
      s_axis_tready[last_grant] = out_ready;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = BUSY;
          last_grant_n = pick;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(S_COUNT - 1);
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tlast  <= sel_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_SRC_ID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tid <= '0;
    end else if (accept) begin
      m_axis_tid <= last_grant;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed steps plus randomized traffic checked
// against a packet-queue round-robin model.
module tb_axis_rr_arbiter;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
`ifdef AXIS_ARB_SRC_ID_EN
  logic [GW-1:0]   m_tid;
`endif

  axis_rr_arbiter #(
    .S_COUNT(S),
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
`ifdef AXIS_ARB_SRC_ID_EN
    .m_axis_tid(m_tid),
`endif
    .m_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [GW-1:0] src;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;

  beat_t src_q[S][$];
  beat_t exp_q[$];
  int    pk_left[S];
  logic  mid[S];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int s, logic v, logic [DW-1:0] d, logic [KW-1:0] k, logic l);
    s_tvalid[s] = v;
    s_tdata[s*DW +: DW] = d;
    s_tkeep[s*KW +: KW] = k;
    s_tlast[s] = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_tid(string tag, int exp);
`ifdef AXIS_ARB_SRC_ID_EN
    chk(tag, m_tid, exp);
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    int ptr;
    int want;
    int cyc;
    int nacc;
    int cur;
    bit done;
    beat_t b;
    beat_t e;

    rst = 1'b1;
    m_tready = 1'b1;
    s_tdata = '0;
    s_tkeep = '0;
    s_tvalid = '0;
    s_tlast = '0;
    #1;
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_keep", m_tkeep, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_ready", s_tready, 0);
    chk_tid("rst_tid", 0);

    // single source, stream 1
    tick(); rst = 1'b0;
    drive(1, 1, 8'h11, 1, 0); #1;
    chk("s1_idle_ready", s_tready, 0);
    tick(); #1;
    chk("s1_grant", s_tready, 4'b0010);
    chk("s1_novalid", m_tvalid, 0);
    tick(); drive(1, 1, 8'h12, 1, 0); #1;
    chk("s1_b0", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h11, 1'b0});
    chk_tid("s1_tid", 1);
    tick(); drive(1, 1, 8'h13, 1, 1); #1;
    chk("s1_b1", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h12, 1'b0});
    tick(); drive(1, 0, 0, 0, 0); #1;
    chk("s1_b2", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h13, 1'b1});
    chk("s1_release", s_tready, 0);
    tick(); #1;
    chk("s1_drain", m_tvalid, 0);

    // backpressure on stream 0
    drive(0, 1, 8'hA0, 1, 0);
    tick(); #1;
    chk("bp_grant", s_tready, 4'b0001);
    tick(); drive(0, 1, 8'hA1, 1, 0); #1;
    chk("bp_a0", {m_tvalid, m_tdata}, {1'b1, 8'hA0});
    tick(); m_tready = 1'b0; drive(0, 1, 8'hA2, 1, 0); #1;
    chk("bp_a1", {m_tvalid, m_tdata}, {1'b1, 8'hA1});
    chk("bp_rdy0", s_tready, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("bp_hold", {m_tvalid, m_tdata}, {1'b1, 8'hA1});
      chk("bp_stall_rdy", s_tready, 0);
    end
    tick(); m_tready = 1'b1; #1;
    chk("bp_hold_end", m_tdata, 8'hA1);
    chk("bp_resume", s_tready, 4'b0001);
    tick(); drive(0, 1, 8'hA3, 1, 1); #1;
    chk("bp_a2", {m_tvalid, m_tdata}, {1'b1, 8'hA2});
    tick(); drive(0, 0, 0, 0, 0); #1;
    chk("bp_a3", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'hA3, 1'b1});
    tick(); #1;
    chk("bp_drain", m_tvalid, 0);

    // source gap: stream 2 granted, stream 3 waiting
    drive(2, 1, 8'h21, 1, 0);
    drive(3, 1, 8'h31, 1, 1);
    tick(); #1;
    chk("gap_grant", s_tready, 4'b0100);
    tick(); drive(2, 0, 0, 0, 0); #1;
    chk("gap_b0", {m_tvalid, m_tdata}, {1'b1, 8'h21});
    chk("gap_rdy_a", s_tready, 4'b0100);
    tick(); #1;
    chk("gap_empty", m_tvalid, 0);
    chk("gap_rdy_b", s_tready, 4'b0100);
    tick(); drive(2, 1, 8'h22, 1, 1); #1;
    chk("gap_rdy_c", s_tready, 4'b0100);
    tick(); drive(2, 0, 0, 0, 0); #1;
    chk("gap_b1", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h22, 1'b1});
    chk("gap_idle", s_tready, 0);
    tick(); #1;
    chk("gap_s3_grant", s_tready, 4'b1000);
    tick(); drive(3, 0, 0, 0, 0); #1;
    chk("gap_s3", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h31, 1'b1});
    chk_tid("gap_tid", 3);

    // single-beat packets from streams 0 and 1
    drive(0, 1, 8'h50, 1, 1);
    drive(1, 1, 8'h61, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(); #1;
      chk("sb_valid", m_tvalid, (k % 2) == 0);
      if (k % 2 == 0) begin
        chk("sb_data", m_tdata, ((k / 2 - 1) % 2 == 0) ? 8'h50 : 8'h61);
      end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // reset mid-packet on stream 2
    tick(); drive(2, 1, 8'h71, 1, 0);
    tick(); #1;
    chk("rm_grant", s_tready, 4'b0100);
    tick(); drive(2, 1, 8'h72, 1, 0); drive(0, 1, 8'h81, 1, 1); #1;
    chk("rm_b0", {m_tvalid, m_tdata}, {1'b1, 8'h71});
    tick(); rst = 1'b1; #1;
    chk("rm_clear", {m_tvalid, m_tdata, m_tkeep, m_tlast}, 0);
    chk("rm_rdy", s_tready, 0);
    chk_tid("rm_tid", 0);
    tick(); rst = 1'b0;
    tick(); #1;
    chk("rm_regrant", s_tready, 4'b0001);
    tick(); drive(0, 0, 0, 0, 0); drive(2, 0, 0, 0, 0); #1;
    chk("rm_s0", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h81, 1'b1});
    tick();

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      rst = 1'b1;
      s_tvalid = '0;
      exp_q.delete();
      for (int s = 0; s < S; s++) begin
        src_q[s].delete();
        mid[s] = 1'b0;
        pk_left[s] = $urandom_range(0, 4);
        for (int p = 0; p < pk_left[s]; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            b.d = DW'($urandom);
            b.k = KW'($urandom);
            b.l = (j == len - 1);
            b.src = GW'(s);
            src_q[s].push_back(b);
          end
        end
      end
      ptr = S - 1;
      cur = -1;
      cyc = 0;
      done = 1'b0;
      tick(); rst = 1'b0;
      while (!done && cyc < 3000) begin
        tick();
        cyc++;
        m_tready = ($urandom_range(0, 3) != 0);
        for (int s = 0; s < S; s++) begin
          if (src_q[s].size() > 0) begin
            b = src_q[s][0];
            drive(s, !(mid[s] && $urandom_range(0, 2) == 0), b.d, b.k, b.l);
          end else begin
            drive(s, 0, 0, 0, 0);
          end
        end
        #1;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("rnd_spurious", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rnd_beat", {m_tdata, m_tkeep, m_tlast}, {e.d, e.k, e.l});
            chk_tid("rnd_tid", int'(e.src));
          end
        end
        nacc = 0;
        for (int s = 0; s < S; s++) begin
          if (s_tvalid[s] && s_tready[s]) begin
            nacc++;
            if (cur < 0) begin
              want = -1;
              for (int k = 1; k <= S; k++) begin
                if (want < 0 && pk_left[(ptr + k) % S] > 0) want = (ptr + k) % S;
              end
              chk("rnd_rr", s, want);
              ptr = s;
              cur = s;
            end else begin
              chk("rnd_lock", s, cur);
            end
            b = src_q[s].pop_front();
            exp_q.push_back(b);
            mid[s] = !b.l;
            if (b.l) begin
              pk_left[s]--;
              cur = -1;
            end
          end
        end
        if (nacc > 1) chk("rnd_multi", nacc, 1);
        done = (exp_q.size() == 0) && !m_tvalid;
        for (int s = 0; s < S; s++) begin
          if (src_q[s].size() > 0) done = 1'b0;
        end
      end
      chk("rnd_timeout", done, 1);
      s_tvalid = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one downstream AXI-Stream processing element between S_COUNT upstream AXI-Stream sources. It grants one source at a time, forwards that source's packet beat by beat through a single output register stage, and releases the grant only on the accepted tlast beat. It sits in front of per-sample streaming blocks so that several producers can time-share one datapath without interleaving packets.

## Interface
- S_COUNT, 4: number of input streams, 2..16
- DATA_WIDTH, 8: tdata width per stream
- KEEP_WIDTH, (DATA_WIDTH+7)/8: tkeep width per stream
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data; stream i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input byte enables, packed as tdata
- s_axis_tvalid  in  S_COUNT  per-stream valid
- s_axis_tready  out  S_COUNT  per-stream ready
- s_axis_tlast  in  S_COUNT  per-stream end of packet
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of packet

## Operation
- FSM states: IDLE, BUSY. Reset state IDLE.
- Pointer last_grant (clog2(S_COUNT) bits, min 1), reset S_COUNT-1, so the first grant goes to stream 0.
- IDLE: if any s_axis_tvalid[i] is high, select the first asserted index searching last_grant+1, last_grant+2, ... modulo S_COUNT. Register it as grant and last_grant, then go to BUSY. If no valid is high, stay in IDLE. All s_axis_tready stay 0 in IDLE.
- BUSY: s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other tready bits are 0.
- An input beat is accepted when s_axis_tvalid[grant] and s_axis_tready[grant] are both high. On acceptance, tdata, tkeep and tlast load into the output register and m_axis_tvalid is set.
- The output register holds its value while m_axis_tvalid && !m_axis_tready.
- m_axis_tvalid clears when m_axis_tready is high and no new beat is accepted in the same cycle.
- Acceptance of a beat with tlast = 1 moves the FSM to IDLE. The grant is never released mid-packet.
- A granted source that drops tvalid mid-packet keeps the grant. The FSM waits in BUSY; no timeout.
- Single-beat packets (tlast on the first beat) are legal: the FSM goes BUSY for one accepted beat, then returns to IDLE.
- tkeep is forwarded unmodified.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0
  - s_axis_tready = 0
  - FSM = IDLE, last_grant = S_COUNT-1
- Arbitration latency: tvalid seen in IDLE at cycle n gives grant at n+1; tready can assert at n+1.
- Data latency: a beat accepted at cycle n is presented on m_axis at cycle n+1.
- Throughput: one beat per cycle within a packet while m_axis_tready = 1. Exactly one idle input cycle (the IDLE state) between packets.
- Simultaneous requests: round-robin order from last_grant+1. A source requesting continuously waits at most S_COUNT-1 packets.
- Backpressure: with m_axis_tready = 0 and m_axis_tvalid = 1, tready to the granted source is 0 the same cycle (combinational from m_axis_tready). No beat is lost or duplicated.
- The final output beat may still be stalled downstream when the FSM re-enters IDLE. The next grant proceeds, but its first beat waits on the output register.
- Reset asserted mid-packet: clear immediately to reset values. The partial packet is dropped with no tlast emitted, and arbitration restarts at stream 0.

## Configuration
- AXIS_ARB_SRC_ID_EN defined:
  - Adds output port m_axis_tid, width clog2(S_COUNT) (min 1).
  - It is registered alongside m_axis_tdata with the grant index of the beat, held under stall, and resets to 0.
- AXIS_ARB_SRC_ID_EN undefined: the port and its register do not exist; all other behaviour is identical.

## Test plan
- Single source: stream 1 sends a 3-beat packet 0x11, 0x12, 0x13 (tlast on 0x13) with m_axis_tready = 1 → output 0x11..0x13 on consecutive cycles starting 2 cycles after tvalid, tlast only on 0x13, m_axis_tid = 1 if enabled.
- Contention: streams 0, 2 and 3 all hold 2-beat packets from reset → output packet order 0, 2, 3, then 0 again if it re-requests. No beats interleave.
- Backpressure: during stream 0's 4-beat packet 0xA0..0xA3, drive m_axis_tready low for 3 cycles on beat 2 → m_axis_tdata holds 0xA1 stable, s_axis_tready[0] = 0 during the stall, and all 4 beats are delivered exactly once.
- Source gap: granted stream 2 deasserts tvalid for 2 cycles mid-packet while stream 3 is valid → stream 3 gets no tready until stream 2's tlast is accepted.
- Single-beat packets: streams 0 and 1 continuously send 1-beat packets → output alternates 0, 1, 0, 1 with one valid beat every 2 cycles.
- Reset mid-packet: assert rst after beat 1 of a 3-beat packet on stream 2 → all outputs 0 the same cycle. After release, the next grant goes to stream 0 if it is requesting.
